// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII transmit framer.
// The FCS_EN-only state is present when GMII_TX_FCS_EN is defined.
package gmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
`ifdef GMII_TX_FCS_EN
    ST_FCS,
`endif
    ST_DROP,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY_REFL = rev32(CRC_POLY);

  // Reflected (LSB-first) CRC-32 update for one byte, as Ethernet transmits it.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/gmii_tx_framer_crc.sv
// Byte-wide CRC-32 register (crc32_d8); used by gmii_tx_framer only when
// GMII_TX_FCS_EN is defined.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = CRC_INIT;
    else if (en) crc_d = crc32_byte(crc_q, data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// Ethernet transmit framer: preamble/SFD, data, zero pad, optional FCS
// (enabled by GMII_TX_FCS_EN), underrun drop and inter-frame gap.
//
// state | meaning
// IDLE  | waiting for a complete frame in the FIFO
// PRE   | sending PREAMBLE_LEN x 0x55
// SFD   | sending 0xD5
// DATA  | popping and forwarding payload bytes
// PAD   | zero bytes up to MIN_LEN
// FCS   | four inverted CRC bytes, LSB first
// DROP  | discarding the rest of an underrun frame
// IFG   | IFG_LEN idle cycles
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int MIN_LEN      = 60
) (
  input  logic       gmii_gtx_clk,
  input  logic       sys_rst_n,
  input  logic       src_frame_ready,
  input  logic       src_empty,
  input  logic [8:0] src_dout,
  output logic       src_rd_en,
  output logic       fifo_en,
  output logic [7:0] fifo_din,
  output logic       tx_underrun,
  output logic       tx_busy
);

  localparam int TW = 8;

`ifdef GMII_TX_FCS_EN
  localparam tx_state_e      TAIL_ST  = ST_FCS;
  localparam logic [TW-1:0]  TAIL_TMR = TW'(3);
`else
  localparam tx_state_e      TAIL_ST  = ST_IFG;
  localparam logic [TW-1:0]  TAIL_TMR = TW'(IFG_LEN - 1);
`endif

  tx_state_e     state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [10:0]   cnt_q, cnt_d;
  logic          en_q, en_d;
  logic [7:0]    din_q, din_d;
  logic          ur_q, ur_d;
  logic [10:0]   cnt_inc;
  logic          below_min;

`ifdef GMII_TX_FCS_EN
  logic [31:0]   crc_val;
`endif

  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 11'd1;
  assign below_min = ({1'b0, cnt_q} + 12'd1) < 12'(MIN_LEN);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    en_d      = 1'b0;
    din_d     = 8'h00;
    ur_d      = 1'b0;
    src_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (src_frame_ready) begin
          state_d = ST_PRE;
          tmr_d   = TW'(PREAMBLE_LEN - 1);
          cnt_d   = '0;
        end
      end
      ST_PRE: begin
        en_d  = 1'b1;
        din_d = PREAMBLE_BYTE;
        if (tmr_q == '0) state_d = ST_SFD;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_SFD: begin
        en_d    = 1'b1;
        din_d   = SFD_BYTE;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (src_empty) begin
          ur_d    = 1'b1;
          state_d = ST_DROP;
        end else begin
          src_rd_en = 1'b1;
          en_d      = 1'b1;
          din_d     = src_dout[7:0];
          cnt_d     = cnt_inc;
          if (src_dout[8]) begin
            state_d = below_min ? ST_PAD : TAIL_ST;
            tmr_d   = TAIL_TMR;
          end
        end
      end
      ST_PAD: begin
        en_d  = 1'b1;
        cnt_d = cnt_inc;
        if (!below_min) begin
          state_d = TAIL_ST;
          tmr_d   = TAIL_TMR;
        end
      end
`ifdef GMII_TX_FCS_EN
      ST_FCS: begin
        en_d = 1'b1;
        case (tmr_q[1:0])
          2'd3:    din_d = ~crc_val[7:0];
          2'd2:    din_d = ~crc_val[15:8];
          2'd1:    din_d = ~crc_val[23:16];
          default: din_d = ~crc_val[31:24];
        endcase
        if (tmr_q == '0) begin
          state_d = ST_IFG;
          tmr_d   = TW'(IFG_LEN - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`endif
      ST_DROP: begin
        if (!src_empty) begin
          src_rd_en = 1'b1;
          if (src_dout[8]) begin
            state_d = ST_IFG;
            tmr_d   = TW'(IFG_LEN - 1);
          end
        end
      end
      ST_IFG: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gmii_gtx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      din_q   <= 8'h00;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      din_q   <= din_d;
      ur_q    <= ur_d;
    end
  end

`ifdef GMII_TX_FCS_EN
  // CRC covers exactly the bytes leaving DATA and PAD; it holds steady during FCS.
  crc32_d8 u_crc (
    .clk   (gmii_gtx_clk),
    .rst_n (sys_rst_n),
    .clr   (state_q == ST_IDLE),
    .en    (en_d && (state_q == ST_DATA || state_q == ST_PAD)),
    .data  (din_d),
    .crc   (crc_val)
  );
`endif

  assign fifo_en     = en_q;
  assign fifo_din    = din_q;
  assign tx_underrun = ur_q;
  assign tx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer with a FWFT FIFO model and output monitor.
// Expectations follow GMII_TX_FCS_EN when it is defined for the build.
module tb_gmii_tx_framer;

  localparam int PRE_LEN = 7;
  localparam int IFG     = 12;
  localparam int MIN_LEN = 60;
`ifdef GMII_TX_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       src_frame_ready;
  logic       src_empty;
  logic [8:0] src_dout;
  logic       src_rd_en;
  logic       fifo_en;
  logic [7:0] fifo_din;
  logic       tx_underrun;
  logic       tx_busy;

  always #4 clk = ~clk;

  gmii_tx_framer dut (
    .gmii_gtx_clk    (clk),
    .sys_rst_n       (sys_rst_n),
    .src_frame_ready (src_frame_ready),
    .src_empty       (src_empty),
    .src_dout        (src_dout),
    .src_rd_en       (src_rd_en),
    .fifo_en         (fifo_en),
    .fifo_din        (fifo_din),
    .tx_underrun     (tx_underrun),
    .tx_busy         (tx_busy)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  logic [8:0] q[$];
  logic [7:0] pl[$];
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  int  frames_in_q = 0;
  int  popped      = 0;
  bit  hold_empty  = 0;
  bit  arm_ur      = 0;
  bit  pop_pending = 0;
  int  low_cnt     = 0;
  int  run_cnt     = 0;
  int  last_run    = 0;
  int  last_gap    = 0;
  int  ur_cnt      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic update_src();
    src_empty       = hold_empty || (q.size() == 0);
    src_dout        = (q.size() != 0) ? q[0] : 9'h000;
    src_frame_ready = (frames_in_q > 0);
  endtask

  task automatic do_pop();
    logic [8:0] w;
    w = q.pop_front();
    popped++;
    if (w[8]) begin
      frames_in_q--;
      popped = 0;
    end else if (arm_ur && popped == 20) begin
      hold_empty = 1;
      arm_ur     = 0;
    end
    update_src();
  endtask

  task automatic sample();
    if (fifo_en === 1'b1) begin
      rx.push_back(fifo_din);
      if (low_cnt > 0) last_gap = low_cnt;
      low_cnt = 0;
      run_cnt++;
    end else begin
      if (run_cnt > 0) last_run = run_cnt;
      run_cnt = 0;
      low_cnt++;
    end
    if (tx_underrun === 1'b1) ur_cnt++;
  endtask

  // One clock: decide the pop before the edge, update the FIFO just after it,
  // observe the DUT on the falling edge.
  task automatic tick();
    #1;
    pop_pending = (src_rd_en === 1'b1);
    @(posedge clk);
    #1;
    if (pop_pending && q.size() != 0) do_pop();
    @(negedge clk);
    sample();
  endtask

  task automatic make_seq(input int n, input logic [7:0] first);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'(first + 8'(i)));
  endtask

  task automatic push_payload();
    for (int i = 0; i < pl.size(); i++) q.push_back({(i == pl.size() - 1), pl[i]});
    frames_in_q++;
    update_src();
  endtask

  // Non-reflected CRC-32 step over a bit-reversed byte; equivalent to the
  // Ethernet LSB-first CRC once the register is reversed at the end.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic [7:0]  br;
    for (int i = 0; i < 8; i++) br[i] = b[7-i];
    r = c ^ {br, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  function automatic logic [31:0] rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic exp_pre();
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
  endtask

  task automatic exp_full();
    logic [31:0] c;
    logic [31:0] f;
    int n;
    c = 32'hFFFF_FFFF;
    exp_pre();
    n = (pl.size() < MIN_LEN) ? MIN_LEN : pl.size();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = (i < pl.size()) ? pl[i] : 8'h00;
      exp_q.push_back(b);
      c = crc_step(c, b);
    end
    f = ~rev(c);
    for (int i = 0; i < FCS_BYTES; i++) exp_q.push_back(f[8*i +: 8]);
  endtask

  task automatic exp_partial(input int k);
    exp_pre();
    for (int i = 0; i < k; i++) exp_q.push_back(pl[i]);
  endtask

  task automatic check_stream(input string tag);
    int n;
    bit bad;
    bad = 0;
    chk({tag, "_len"}, 32'(rx.size()), 32'(exp_q.size()));
    n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    for (int i = 0; i < n && !bad; i++) begin
      n_asserts++;
      assert (rx[i] === exp_q[i]) else begin
        n_fail++;
        bad = 1;
        $error("FAIL %s[%0d]: observed %h expected %h", tag, i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic clear_obs();
    rx.delete();
    exp_q.delete();
    ur_cnt = 0;
  endtask

  // Runs until the FIFO is drained and the framer is back in IDLE.
  task automatic wait_done(input string tag, input int budget);
    int k;
    bit done;
    k = 0;
    done = 0;
    while (!done && k < budget) begin
      tick();
      k++;
      done = (tx_busy === 1'b0) && (frames_in_q == 0) && (q.size() == 0) && !hold_empty;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ifg"}, 32'(low_cnt), 32'(IFG));
  endtask

  initial begin
    int k;
    sys_rst_n = 1'b0;
    update_src();
    tick();
    tick();
    chk("rst_fifo_en", 32'(fifo_en), 32'd0);
    chk("rst_fifo_din", 32'(fifo_din), 32'd0);
    chk("rst_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_rd_en", 32'(src_rd_en), 32'd0);
    sys_rst_n = 1'b1;
    tick();
    tick();

    // 60-byte frame 0x01..0x3C: no padding, start latency and run length.
    clear_obs();
    make_seq(60, 8'h01);
    push_payload();
    exp_full();
    tick();
    chk("lat_idle_en", 32'(fifo_en), 32'd0);
    chk("lat_busy", 32'(tx_busy), 32'd1);
    tick();
    chk("lat_first_en", 32'(fifo_en), 32'd1);
    chk("lat_first_byte", 32'(fifo_din), 32'h55);
    chk("pre_rd_en", 32'(src_rd_en), 32'd0);
    wait_done("f60", 600);
    chk("f60_run", 32'(last_run), 32'(68 + FCS_BYTES));
    check_stream("f60");

    // "123456789": 51 pad bytes, FCS over the padded payload.
    clear_obs();
    make_seq(9, 8'h31);
    push_payload();
    exp_full();
    wait_done("f9", 600);
    check_stream("f9");
    if (FCS_BYTES != 0 && rx.size() >= 72) begin
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 72; i++) c = crc_step(c, rx[i]);
      chk("f9_residue", c, 32'hC704DD7B);
    end

    // Back-to-back: 59 bytes (one pad byte) then 61 bytes (no pad).
    clear_obs();
    make_seq(59, 8'h80);
    push_payload();
    exp_full();
    make_seq(61, 8'hA0);
    push_payload();
    exp_full();
    wait_done("b2b", 1200);
    chk("b2b_gap", 32'(last_gap), 32'(IFG + 1));
    check_stream("b2b");

    // Underrun after byte 20 of 100, then an intact 60-byte frame.
    clear_obs();
    arm_ur = 1;
    make_seq(100, 8'h10);
    push_payload();
    exp_partial(20);
    make_seq(60, 8'hC0);
    push_payload();
    exp_full();
    k = 0;
    while (ur_cnt == 0 && k < 400) begin
      tick();
      k++;
    end
    chk("ur_seen", 32'(ur_cnt != 0), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("ur_hold_rd_en", 32'(src_rd_en), 32'd0);
    chk("ur_hold_en", 32'(fifo_en), 32'd0);
    chk("ur_hold_busy", 32'(tx_busy), 32'd1);
    hold_empty = 0;
    update_src();
    wait_done("ur", 1500);
    chk("ur_pulses", 32'(ur_cnt), 32'd1);
    check_stream("ur");

    // Reset in the frame tail (FCS when present, otherwise padding).
    clear_obs();
    make_seq(9, 8'h31);
    push_payload();
    k = 0;
    while (rx.size() < ((FCS_BYTES != 0) ? 69 : 28) && k < 400) begin
      tick();
      k++;
    end
    chk("rst_mid_reached", 32'(k < 400), 32'd1);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 32'(fifo_en), 32'd0);
    chk("rst_mid_busy", 32'(tx_busy), 32'd0);
    chk("rst_mid_din", 32'(fifo_din), 32'd0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("rst_rel_busy", 32'(tx_busy), 32'd0);
    chk("rst_rel_en", 32'(fifo_en), 32'd0);
    clear_obs();
    make_seq(64, 8'h40);
    push_payload();
    exp_full();
    wait_done("post_rst", 600);
    check_stream("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
# gmii_tx_framer

Transmit framing stage directly upstream of the GMII output hub. It pulls complete frames from the transmit FIFO, prepends preamble and SFD, pads short frames to the Ethernet minimum and optionally appends FCS. It then enforces the inter-frame gap. The result is a byte stream on `fifo_en`/`fifo_din`, which the hub registers onto `gmii_en`/`gmii_dout`.

## Interface
- `PREAMBLE_LEN`, default 7: number of 0x55 bytes sent before the SFD.
- `IFG_LEN`, default 12: number of idle cycles (`fifo_en`=0) after each frame.
- `MIN_LEN`, default 60: minimum payload byte count; shorter frames are zero-padded up to this length.
- `gmii_gtx_clk` in 1: single clock, 125 MHz.
- `sys_rst_n` in 1: reset, asynchronous and active-low.
- `src_frame_ready` in 1: at least one complete frame is in the FIFO.
- `src_empty` in 1: FIFO empty flag. The FIFO is first-word-fall-through.
- `src_dout` in 9: bit 8 marks the last byte of a frame; bits 7:0 are data.
- `src_rd_en` out 1: FIFO pop. Combinational from state and `src_empty`.
- `fifo_en` out 1: output byte valid. Registered.
- `fifo_din` out 8: output byte. Registered.
- `tx_underrun` out 1: one-cycle pulse when the FIFO runs empty mid-frame.
- `tx_busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS (only with FCS_EN), DROP, IFG.
- IDLE:
  - If `src_frame_ready` is 1, go to PRE and clear the counters.
  - Otherwise stay in IDLE.
- PRE: emit 0x55 for PREAMBLE_LEN cycles, then go to SFD.
- SFD: emit 0xD5 for one cycle, then go to DATA.
- DATA: `src_rd_en` = !`src_empty`; emit `src_dout[7:0]`.
  - An 11-bit byte counter increments and saturates at 2047.
  - When bit 8 is set, the frame ends. The next state is:
    - PAD if count+1 < MIN_LEN;
    - otherwise FCS (FCS_EN) or IFG (no FCS_EN).
- PAD: emit 0x00 until count reaches MIN_LEN, then go to FCS or IFG.
- FCS: emit four bytes, least significant byte first: ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24]. Then go to IFG.
- Underrun: `src_empty`=1 while in DATA.
  - Do not emit a byte that cycle.
  - Pulse `tx_underrun` and go to DROP.
  - No FCS and no padding are sent for that frame.
- DROP: pop while not empty until a byte with bit 8 set is popped, then go to IFG. No output is emitted.
- IFG: `fifo_en`=0 for IFG_LEN cycles, then go to IDLE.
- `src_dout` is ignored outside DATA and DROP. `src_rd_en` is 0 outside DATA and DROP.

## Timing
- Reset values:
  - `fifo_en`=0, `fifo_din`=0x00, `tx_underrun`=0, `tx_busy`=0.
  - State IDLE, all counters 0, CRC register 0xFFFFFFFF.
- Reset asserted mid-frame: outputs drop immediately (asynchronous); the frame is abandoned with no FCS.
- Latency, start of frame: `src_frame_ready` sampled high at edge N gives the first 0x55 on `fifo_en` after edge N+1.
- Latency, data: a byte popped at edge M appears on `fifo_din` after edge M (one register stage).
- `fifo_en` is continuous from the first preamble byte to the last FCS or pad byte. The only gap permitted is an underrun.
- Back-to-back frames: `fifo_en` is low for exactly IFG_LEN cycles, plus one cycle for the IDLE decision.
- `src_frame_ready` is not re-sampled until IDLE.
- A frame that ends at count ≥ 2047 still completes normally.

## Configuration
- `GMII_TX_FCS_EN`:
  - Defined: CRC-32 (polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF) is computed over data and pad bytes, and the FCS state appends it.
  - Undefined: no CRC logic and no FCS state; the frame ends after the last data or pad byte.

## Structure
- Package `gmii_pkg`:
  - state enum;
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_INIT=0xFFFFFFFF;
  - CRC polynomial.
- Sub-module `crc32_d8`: one byte per cycle, with inputs clear and enable, and a 32-bit output. It is instantiated only under GMII_TX_FCS_EN.

## Test plan
- 60-byte frame 0x01..0x3C (FCS_EN) → 7×0x55, 0xD5, 60 data bytes, 4 FCS bytes, then 12 idle cycles; 72 consecutive `fifo_en` cycles.
- 9-byte frame "123456789" (FCS_EN) → 51 zero pad bytes, then an FCS equal to the software CRC-32 of the 60-byte padded payload; the receiver's CRC residue is 0xC704DD7B.
- Two frames queued → gap between the last FCS byte of frame 1 and the first 0x55 of frame 2 is exactly 13 cycles with `fifo_en` low.
- `src_empty` forced high after byte 20 of a 100-byte frame → `tx_underrun` pulses once and no FCS is sent. After refill, the remaining bytes are popped without output. The next frame is sent intact.
- `sys_rst_n` pulled low during the FCS state → `fifo_en`=0 at once. After release, the block is in IDLE and the next frame starts with a full preamble.
- FCS_EN undefined, 60-byte frame → 68 `fifo_en` cycles and no FCS bytes.
